ack_bus_requester: RTL and testbench

Source-side endpoint of the acknowledge bus, instantiated once inside each of the mem, sha, aes and ctrl units. It counts completion pulses from its host unit and raises `req` toward the ack bus arbiter. It retires one pending ack per grant (`ack_ready`). After every grant it backs off for a programmable number of cycles so lower-priority sources can win the fixed-priority arbiter.

---
 rtl/ack_bus_if.sv | 32 +++
 rtl/ack_bus_requester.sv | 107 ++++++++++
 tb/tb_ack_bus_requester.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/ack_bus_if.sv
// Acknowledge-bus endpoint interface.
// Bundles the host-side completion input, the arbiter handshake and the
// endpoint's status outputs for one ack_bus_requester.
//   done_pulse : host unit completed one operation (one ack per high cycle)
//   ack_ready  : grant from the arbiter for this source
//   req        : request toward the arbiter
//   ack_sent   : req & ack_ready, one ack delivered this cycle
//   pending    : acks queued and not yet granted
//   overflow   : sticky, a completion was dropped because the queue was full
//   busy       : endpoint not idle or acks still queued
// master modport: the requester endpoint. slave modport: host/arbiter side.
interface ack_bus_if #(
  parameter int CNT_W = 3
);
  logic             done_pulse;
  logic             ack_ready;
  logic             req;
  logic             ack_sent;
  logic [CNT_W-1:0] pending;
  logic             overflow;
  logic             busy;

  modport master (
    input  done_pulse, ack_ready,
    output req, ack_sent, pending, overflow, busy
  );

  modport slave (
    output done_pulse, ack_ready,
    input  req, ack_sent, pending, overflow, busy
  );
endinterface

// File: rtl/ack_bus_requester.sv
// Source-side endpoint of the acknowledge bus.
// Counts completion pulses from the host unit, requests the fixed-priority
// ack arbiter while acks are queued, retires one ack per grant and then
// backs off for COOLDOWN cycles so lower-priority sources get a turn.
// Ports:
//   clk   : single clock, all state updates on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : ack_bus_if master modport (done_pulse, ack_ready in;
//           req, ack_sent, pending, overflow, busy out)
module ack_bus_requester #(
  parameter int MAX_PENDING = 7,
  parameter int CNT_W       = 3,
  parameter int COOLDOWN    = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  ack_bus_if.master bus
);

  localparam int               CCW       = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam logic [CNT_W-1:0] MAX_P     = CNT_W'(MAX_PENDING);
  localparam logic [CCW-1:0]   COOL_INIT = (COOLDOWN >= 1) ? CCW'(COOLDOWN - 1) : '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    COOL = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic             overflow_q, overflow_d;
  logic [CCW-1:0]   cool_q, cool_d;

  logic req;
  logic ack_sent;
  logic full;
  logic inc;
  logic dec;

  // req is decoded from registered state only, so ack_ready never feeds
  // back into req through the arbiter.
  assign req      = (state_q == REQ);
  assign ack_sent = req & bus.ack_ready;

  // The full check uses the current count: a grant in the same cycle does
  // not make room for an incoming pulse.
  assign full = (pending_q == MAX_P);
  assign inc  = bus.done_pulse & ~full;
  assign dec  = ack_sent;

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    overflow_d = overflow_q | (bus.done_pulse & full);
    cool_d     = cool_q;

    case ({inc, dec})
      2'b10:   pending_d = pending_q + 1'b1;
      2'b01:   pending_d = pending_q - 1'b1;
      default: pending_d = pending_q;
    endcase

    case (state_q)
      IDLE: begin
        if (bus.done_pulse || (pending_q != '0)) state_d = REQ;
      end
      REQ: begin
        // Without a grant the request is held indefinitely.
        if (ack_sent) begin
          if (COOLDOWN >= 1) begin
            state_d = COOL;
            cool_d  = COOL_INIT;
          end else if (pending_d == '0) begin
            state_d = IDLE;
          end
        end
      end
      COOL: begin
        if (cool_q == '0) state_d = (pending_d != '0) ? REQ : IDLE;
        else              cool_d  = cool_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      overflow_q <= 1'b0;
      cool_q     <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      cool_q     <= cool_d;
    end
  end

  assign bus.req      = req;
  assign bus.ack_sent = ack_sent;
  assign bus.pending  = pending_q;
  assign bus.overflow = overflow_q;
  assign bus.busy     = (state_q != IDLE) || (pending_q != '0);

endmodule

// File: tb/tb_ack_bus_requester.sv
// Testbench for ack_bus_requester: directed scenarios followed by random
// traffic, checked against a queue-count reference model through a
// scoreboard drained by an independent monitor.
module tb_ack_bus_requester;

  localparam int MAXP = 7;
  localparam int CW   = 3;
  localparam int COOL = 1;

  logic clk;
  logic rst_n;

  ack_bus_if #(.CNT_W(CW)) bus();

  ack_bus_requester #(
    .MAX_PENDING(MAXP),
    .CNT_W      (CW),
    .COOLDOWN   (COOL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic          req;
    logic          ack_sent;
    logic [CW-1:0] pending;
    logic          overflow;
    logic          busy;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: number of queued acks, sticky overflow, and the first
  // cycle at which a request may be raised again after the last grant.
  int pend     = 0;
  bit ovf      = 1'b0;
  int earliest = 0;
  int t        = 0;
  bit model_ok = 1'b0;
  bit follow   = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit model_req();
    return (pend > 0) && (t >= earliest);
  endfunction

  // One clock cycle of stimulus: record the expected outputs for this
  // cycle, then advance the model across the rising edge.
  task automatic drive(input logic r, input logic d, input logic a);
    exp_t e;
    logic er;
    er = model_req();
    if (follow) a = bus.req;
    rst_n          = r;
    bus.done_pulse = d;
    bus.ack_ready  = a;
    if (model_ok) begin
      e.req      = er;
      e.ack_sent = er & a;
      e.pending  = CW'(pend);
      e.overflow = ovf;
      e.busy     = (pend > 0) || (t < earliest);
      sb.push_back(e);
    end
    @(posedge clk);
    if (!r) begin
      pend     = 0;
      ovf      = 1'b0;
      earliest = 0;
      model_ok = 1'b1;
    end else begin
      if (d && pend == MAXP) ovf = 1'b1;
      if (d && pend != MAXP) pend++;
      if (er && a) begin
        pend--;
        earliest = t + COOL + 1;
      end
    end
    t++;
    #1;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("req",      8'(bus.req),      8'(e.req));
        chk("ack_sent", 8'(bus.ack_sent), 8'(e.ack_sent));
        chk("pending",  8'(bus.pending),  8'(e.pending));
        chk("overflow", 8'(bus.overflow), 8'(e.overflow));
        chk("busy",     8'(bus.busy),     8'(e.busy));
      end
    end
  end

  initial begin
    rst_n          = 1'b0;
    bus.done_pulse = 1'b0;
    bus.ack_ready  = 1'b0;

    // Reset held two cycles with done_pulse high.
    drive(0, 1, 0);
    drive(0, 1, 0);
    chk("rst_pending",  8'(bus.pending),  8'd0);
    chk("rst_overflow", 8'(bus.overflow), 8'd0);
    chk("rst_busy",     8'(bus.busy),     8'd0);
    repeat (3) drive(1, 0, 0);

    // Single ack with ack_ready following req.
    follow = 1'b1;
    drive(1, 1, 0);
    repeat (4) drive(1, 0, 0);
    follow = 1'b0;

    // Burst of three with the grant always available.
    repeat (3) drive(1, 1, 1);
    repeat (6) drive(1, 0, 1);

    // Stalled grant, then release.
    repeat (2) drive(1, 1, 0);
    repeat (10) drive(1, 0, 0);
    chk("stall_req",     8'(bus.req),     8'd1);
    chk("stall_pending", 8'(bus.pending), 8'd2);
    repeat (6) drive(1, 0, 1);

    // Overflow, drain, and clear by reset.
    repeat (8) drive(1, 1, 0);
    chk("ovf_pending",  8'(bus.pending),  8'd7);
    chk("ovf_overflow", 8'(bus.overflow), 8'd1);
    repeat (16) drive(1, 0, 1);
    chk("drain_pending",  8'(bus.pending),  8'd0);
    chk("drain_overflow", 8'(bus.overflow), 8'd1);
    drive(0, 0, 0);
    chk("ovf_cleared", 8'(bus.overflow), 8'd0);

    // Full queue with simultaneous pulse and grant.
    repeat (7) drive(1, 1, 0);
    drive(1, 1, 1);
    chk("full_sim_pending",  8'(bus.pending),  8'd6);
    chk("full_sim_overflow", 8'(bus.overflow), 8'd1);

    // Reset while cooling down.
    drive(0, 0, 0);
    chk("cool_rst_pending", 8'(bus.pending), 8'd0);
    chk("cool_rst_req",     8'(bus.req),     8'd0);

    // Spurious grants while idle.
    repeat (3) drive(1, 0, 1);
    chk("idle_ack_pending", 8'(bus.pending), 8'd0);

    // Random traffic with occasional resets.
    repeat (400)
      drive($urandom_range(0, 99) >= 2, $urandom_range(0, 99) < 40,
            $urandom_range(0, 99) < 55);

    drive(1, 0, 0);
    repeat (2) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
